// File: rtl/dlx_mem_arbiter_if.sv
// Request/response bundle between the fetch port, the data port, the shared
// memory port and the status outputs of dlx_mem_arbiter.
//   master: arbiter view (drives acks, read data, memory request, status)
//   slave : environment view (requesters plus memory model)
interface dlx_mem_arbiter_if;
  // fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  // data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  // memory port
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  // status
  logic        busy;
  logic        timeout_err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_ack, i_data, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata,
           busy, timeout_err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_ack, i_data, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port.
// One transaction at a time: IDLE -> ACCESS (memory request held until ack or
// timeout) -> DONE (one-cycle ack to the grantee). Ties alternate fairly.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dlx_mem_arbiter_if.master (fetch, data, memory and status signals)
// Every output of the bus is a flop.
module dlx_mem_arbiter #(
  parameter int unsigned PA_BITS        = 24,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  dlx_mem_arbiter_if.master bus
);

  localparam logic [31:0] ADDR_MASK = (PA_BITS >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << PA_BITS) - 32'd1);
  localparam logic [31:0] TMO       = 32'(TIMEOUT_CYCLES);
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;    // current grantee is the data port
  logic        last_d_q, last_d_d;  // last served was the data port
  logic [31:0] cnt_q, cnt_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] i_data_q, i_data_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        sel_d;
  logic        tmo_hit;
  logic [31:0] cap_data;

  // Counter reaching the limit this cycle; m_ack still wins when both occur.
  assign tmo_hit  = TMO_EN && ((cnt_q + 32'd1) == TMO);
  // Timed-out reads return zero.
  assign cap_data = bus.m_ack ? bus.m_rdata : 32'h0;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    i_data_d  = i_data_q;
    d_ack_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    // On a tie the data port wins unless it was served last.
    sel_d     = bus.d_req && (!bus.i_req || !last_d_q);

    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d   = ACCESS;
          gnt_d_d   = sel_d;
          cnt_d     = 32'h0;
          m_req_d   = 1'b1;
          m_addr_d  = (sel_d ? bus.d_addr : bus.i_addr) & ADDR_MASK;
          m_we_d    = sel_d && bus.d_we;
          m_wdata_d = sel_d ? bus.d_wdata : 32'h0;
        end
      end
      ACCESS: begin
        if (bus.m_ack || tmo_hit) begin
          state_d = DONE;
          m_req_d = 1'b0;
          if (!bus.m_ack) err_d = 1'b1;
          if (gnt_d_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = cap_data;
          end else begin
            i_ack_d  = 1'b1;
            i_data_d = cap_data;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        last_d_d = gnt_d_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b0;
      cnt_q     <= 32'h0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      i_ack_q   <= 1'b0;
      i_data_q  <= 32'h0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= 32'h0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      i_data_q  <= i_data_d;
      d_ack_q   <= d_ack_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_req       = m_req_q;
  assign bus.m_we        = m_we_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_wdata     = m_wdata_q;
  assign bus.i_ack       = i_ack_q;
  assign bus.i_data      = i_data_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

endmodule
